// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcode bit positions,
// FSM state encoding, datapath widths and small arithmetic helpers.
package md_pkg;

    localparam int unsigned MD_W     = 32;
    localparam int unsigned MD_OP_W  = 6;
    localparam int unsigned DIV_ITER = 32;

    localparam int unsigned MD_MTHI  = 5;
    localparam int unsigned MD_MTLO  = 4;
    localparam int unsigned MD_MULT  = 3;
    localparam int unsigned MD_MULTU = 2;
    localparam int unsigned MD_DIV   = 1;
    localparam int unsigned MD_DIVU  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic [MD_W-1:0] neg32(input logic [MD_W-1:0] v);
        return MD_W'(~v + MD_W'(1));
    endfunction

    function automatic logic [MD_W-1:0] abs32(input logic [MD_W-1:0] v);
        return v[MD_W-1] ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider step register: one quotient bit per step on
// unsigned magnitudes. Exposes next-step results so the caller can capture
// the final quotient/remainder on the same edge as the last step.
module div_iter
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [MD_W-1:0] i_dividend,
    input  logic [MD_W-1:0] i_divisor,
    output logic [MD_W-1:0] o_quo_nxt,
    output logic [MD_W-1:0] o_rem_nxt
);

    logic [MD_W:0]   r_rem;
    logic [MD_W-1:0] r_quo;
    logic [MD_W-1:0] r_dvs;

    logic [MD_W:0]   w_shift;
    logic [MD_W:0]   w_trial;
    logic            w_ge;
    logic [MD_W:0]   w_rem_nxt;
    logic [MD_W-1:0] w_quo_nxt;

    // Shift in the next dividend bit and try subtracting the divisor.
    always_comb begin
        w_shift   = {r_rem[MD_W-1:0], r_quo[MD_W-1]};
        w_trial   = w_shift - {1'b0, r_dvs};
        w_ge      = r_rem[MD_W] | ~w_trial[MD_W];
        w_rem_nxt = w_ge ? w_trial : w_shift;
        w_quo_nxt = {r_quo[MD_W-2:0], w_ge};
    end

    assign o_quo_nxt = w_quo_nxt;
    assign o_rem_nxt = w_rem_nxt[MD_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multiply/divide responder beside EXE: owns HI/LO, runs a two-cycle multiply
// or an iterative restoring divide, and stalls EXE through md_ready_out.
module mul_div_unit #(
    parameter int unsigned DIV_ITER = md_pkg::DIV_ITER
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exe_valid_in,
    input  logic                       exe_exception_in,
    input  logic [md_pkg::MD_OP_W-1:0] exe_md_op_in,
    input  logic                       exe_md_read_in,
    input  logic [md_pkg::MD_W-1:0]    exe_in0_in,
    input  logic [md_pkg::MD_W-1:0]    exe_in1_in,
    input  logic                       mem_allowin_in,
    input  logic                       wb_ClrStpJmp_in,
    output logic                       md_ready_out,
    output logic [md_pkg::MD_W-1:0]    md_hi_out,
    output logic [md_pkg::MD_W-1:0]    md_lo_out
);

    import md_pkg::*;

    localparam int unsigned CNT_W = $clog2(DIV_ITER);
    localparam int unsigned PROD_W = 2 * MD_W;

    md_state_t r_state;
    md_state_t w_state_nxt;

    logic [MD_W-1:0]  r_hi;
    logic [MD_W-1:0]  r_lo;
    logic [MD_W-1:0]  r_res_hi;
    logic [MD_W-1:0]  r_res_lo;
    logic [MD_W-1:0]  r_mul_a;
    logic [MD_W-1:0]  r_mul_b;
    logic             r_mul_signed;
    logic             r_dz;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [CNT_W-1:0] r_cnt;

    logic              w_flush;
    logic              w_go;
    logic              w_go_commit;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_issue;
    logic              w_div_load;
    logic              w_div_step;
    logic              w_div_last;
    logic              w_done_wr;
    logic              w_mthi_wr;
    logic              w_mtlo_wr;
    logic              w_div_signed;
    logic [MD_W-1:0]   w_dvd_mag;
    logic [MD_W-1:0]   w_dvs_mag;
    logic [MD_W-1:0]   w_quo_nxt;
    logic [MD_W-1:0]   w_rem_nxt;
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;

    assign w_flush      = wb_ClrStpJmp_in;
    assign w_go         = exe_valid_in & ~exe_exception_in & ~w_flush;
    assign w_go_commit  = w_go & mem_allowin_in;
    assign w_is_mul     = exe_md_op_in[MD_MULT] | exe_md_op_in[MD_MULTU];
    assign w_is_div     = exe_md_op_in[MD_DIV]  | exe_md_op_in[MD_DIVU];
    assign w_issue      = (r_state == ST_IDLE) & w_go & (w_is_mul | w_is_div);
    assign w_div_load   = w_issue & ~w_is_mul;
    assign w_div_last   = (r_state == ST_DIV) & (r_cnt == CNT_W'(DIV_ITER - 1));
    assign w_div_signed = exe_md_op_in[MD_DIV];

    assign w_dvd_mag = w_div_signed ? abs32(exe_in0_in) : exe_in0_in;
    assign w_dvs_mag = w_div_signed ? abs32(exe_in1_in) : exe_in1_in;

    // Sign- or zero-extend the latched operands; the low 64 bits of the
    // extended product are the correct signed or unsigned result.
    assign w_a_ext = {{MD_W{r_mul_signed & r_mul_a[MD_W-1]}}, r_mul_a};
    assign w_b_ext = {{MD_W{r_mul_signed & r_mul_b[MD_W-1]}}, r_mul_b};
    assign w_prod  = w_a_ext * w_b_ext;

    div_iter u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_div_load),
        .i_step     (w_div_step),
        .i_dividend (w_dvd_mag),
        .i_divisor  (w_dvs_mag),
        .o_quo_nxt  (w_quo_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, stall and write strobes; flush overrides every transition.
    always_comb begin
        w_state_nxt  = r_state;
        md_ready_out = 1'b1;
        w_div_step   = 1'b0;
        w_done_wr    = 1'b0;
        w_mthi_wr    = 1'b0;
        w_mtlo_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                md_ready_out = ~w_issue;
                if (w_issue) begin
                    w_state_nxt = w_is_mul ? ST_MUL : ST_DIV;
                end else begin
                    w_mthi_wr = w_go_commit & exe_md_op_in[MD_MTHI];
                    w_mtlo_wr = w_go_commit & exe_md_op_in[MD_MTLO];
                end
            end
            ST_MUL: begin
                md_ready_out = 1'b0;
                w_state_nxt  = ST_DONE;
            end
            ST_DIV: begin
                md_ready_out = 1'b0;
                w_div_step   = 1'b1;
                if (w_div_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                md_ready_out = 1'b1;
                if (w_go_commit) begin
                    w_state_nxt = ST_IDLE;
                    w_done_wr   = ~r_dz;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Operand latch at issue, result capture, and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi         <= '0;
            r_lo         <= '0;
            r_res_hi     <= '0;
            r_res_lo     <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_signed <= 1'b0;
            r_dz         <= 1'b0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_issue) begin
                r_mul_a      <= exe_in0_in;
                r_mul_b      <= exe_in1_in;
                r_mul_signed <= exe_md_op_in[MD_MULT];
                r_dz         <= w_div_load & (exe_in1_in == '0);
                r_q_neg      <= w_div_signed & (exe_in0_in[MD_W-1] ^ exe_in1_in[MD_W-1]);
                r_r_neg      <= w_div_signed & exe_in0_in[MD_W-1];
                r_cnt        <= '0;
            end
            if (r_state == ST_MUL) begin
                r_res_hi <= w_prod[PROD_W-1:MD_W];
                r_res_lo <= w_prod[MD_W-1:0];
            end
            if (r_state == ST_DIV) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_div_last) begin
                r_res_lo <= r_q_neg ? neg32(w_quo_nxt) : w_quo_nxt;
                r_res_hi <= r_r_neg ? neg32(w_rem_nxt) : w_rem_nxt;
            end
            if (w_done_wr) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
            if (w_mthi_wr) begin
                r_hi <= exe_in1_in;
            end
            if (w_mtlo_wr) begin
                r_lo <= exe_in1_in;
            end
        end
    end

    assign md_hi_out = r_hi;
    assign md_lo_out = r_lo;

    // HI/LO reads never stall, so the read request only matters to EXE.
    logic w_unused;
    assign w_unused = exe_md_read_in;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mul_div_unit;

    localparam logic [5:0] OP_MTHI  = 6'b100000;
    localparam logic [5:0] OP_MTLO  = 6'b010000;
    localparam logic [5:0] OP_MULT  = 6'b001000;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_DIV   = 6'b000010;
    localparam logic [5:0] OP_DIVU  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid_in;
    logic        exe_exception_in;
    logic [5:0]  exe_md_op_in;
    logic        exe_md_read_in;
    logic [31:0] exe_in0_in;
    logic [31:0] exe_in1_in;
    logic        mem_allowin_in;
    logic        wb_ClrStpJmp_in;
    logic        md_ready_out;
    logic [31:0] md_hi_out;
    logic [31:0] md_lo_out;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk              (clk),
        .rst              (rst),
        .exe_valid_in     (exe_valid_in),
        .exe_exception_in (exe_exception_in),
        .exe_md_op_in     (exe_md_op_in),
        .exe_md_read_in   (exe_md_read_in),
        .exe_in0_in       (exe_in0_in),
        .exe_in1_in       (exe_in1_in),
        .mem_allowin_in   (mem_allowin_in),
        .wb_ClrStpJmp_in  (wb_ClrStpJmp_in),
        .md_ready_out     (md_ready_out),
        .md_hi_out        (md_hi_out),
        .md_lo_out        (md_lo_out)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending result, cycles left before it is ready, HI/LO.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_res_hi = '0;
    logic [31:0] m_res_lo = '0;
    bit          m_pend = 1'b0;
    bit          m_dz = 1'b0;
    int          m_busy = 0;

    function automatic bit model_ready();
        if (m_pend) return (m_busy == 0);
        return !(exe_valid_in && !exe_exception_in && !wb_ClrStpJmp_in && (exe_md_op_in[3:0] != 4'b0));
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] p;
        longint      sa, sb, q, r;
        bit          go;
        go = exe_valid_in && !exe_exception_in;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_pend = 1'b0; m_busy = 0;
        end else if (wb_ClrStpJmp_in) begin
            m_pend = 1'b0; m_busy = 0;
        end else if (m_pend && m_busy > 0) begin
            m_busy--;
        end else if (m_pend) begin
            if (go && mem_allowin_in) begin
                if (!m_dz) begin m_hi = m_res_hi; m_lo = m_res_lo; end
                m_pend = 1'b0;
            end
        end else if (go && exe_md_op_in[3:0] != 4'b0) begin
            sa = longint'($signed(exe_in0_in));
            sb = longint'($signed(exe_in1_in));
            m_dz = 1'b0;
            if (exe_md_op_in[3]) begin
                p = 64'(sa * sb);
                m_res_hi = p[63:32]; m_res_lo = p[31:0]; m_busy = 1;
            end else if (exe_md_op_in[2]) begin
                p = {32'b0, exe_in0_in} * {32'b0, exe_in1_in};
                m_res_hi = p[63:32]; m_res_lo = p[31:0]; m_busy = 1;
            end else begin
                m_busy = 32;
                if (exe_in1_in == 32'd0) begin
                    m_dz = 1'b1;
                end else if (exe_md_op_in[1]) begin
                    q = sa / sb; r = sa % sb;
                    m_res_lo = 32'(q); m_res_hi = 32'(r);
                end else begin
                    m_res_lo = exe_in0_in / exe_in1_in;
                    m_res_hi = exe_in0_in % exe_in1_in;
                end
            end
            m_pend = 1'b1;
        end else if (go && mem_allowin_in) begin
            if (exe_md_op_in[5]) m_hi = exe_in1_in;
            if (exe_md_op_in[4]) m_lo = exe_in1_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check32("cyc_ready", 32'(md_ready_out), 32'(model_ready()));
            check32("cyc_hi", md_hi_out, m_hi);
            check32("cyc_lo", md_lo_out, m_lo);
        end
    end

    task automatic idle();
        exe_valid_in = 1'b0; exe_exception_in = 1'b0; exe_md_op_in = '0;
        exe_md_read_in = 1'b0; exe_in0_in = '0; exe_in1_in = '0;
        mem_allowin_in = 1'b0; wb_ClrStpJmp_in = 1'b0;
    endtask

    // Hold one instruction in EXE until ready; with allow, let it commit.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic allow, output int stall);
        @(posedge clk); #1;
        exe_valid_in = 1'b1; exe_md_op_in = op; exe_in0_in = a; exe_in1_in = b;
        mem_allowin_in = allow;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (md_ready_out) break;
            stall++;
        end
        if (allow) begin
            @(posedge clk); #1;
            idle();
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  st;
        int  r;
        bit  leave;
        logic [5:0] op;

        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check32("rst_hi", md_hi_out, 32'h0);
        check32("rst_lo", md_lo_out, 32'h0);
        check32("rst_ready", 32'(md_ready_out), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(OP_MULT, 32'hFFFFFFFF, 32'h2, 1'b1, st);
        check32("mult_stall", 32'(st), 32'd2);
        check32("mult_hi", md_hi_out, 32'hFFFFFFFF);
        check32("mult_lo", md_lo_out, 32'hFFFFFFFE);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, 1'b1, st);
        check32("multu_stall", 32'(st), 32'd2);
        check32("multu_hi", md_hi_out, 32'h1);
        check32("multu_lo", md_lo_out, 32'hFFFFFFFE);

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, st);
        check32("divu_stall", 32'(st), 32'd33);
        check32("divu_lo", md_lo_out, 32'd14);
        check32("divu_hi", md_hi_out, 32'd2);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, st);
        check32("div_stall", 32'(st), 32'd33);
        check32("div_lo", md_lo_out, 32'hFFFFFFFD);
        check32("div_hi", md_hi_out, 32'hFFFFFFFF);

        run_op(OP_MTHI, 32'h0, 32'h11, 1'b1, st);
        check32("mthi_stall", 32'(st), 32'd0);
        run_op(OP_MTLO, 32'h0, 32'h22, 1'b1, st);
        run_op(OP_DIV, 32'd5, 32'd0, 1'b1, st);
        check32("dz_stall", 32'(st), 32'd33);
        check32("dz_hi", md_hi_out, 32'h11);
        check32("dz_lo", md_lo_out, 32'h22);

        // Flush in cycle T+10 of a divide.
        @(posedge clk); #1;
        exe_valid_in = 1'b1; exe_md_op_in = OP_DIV; exe_in0_in = 32'd1000; exe_in1_in = 32'd3;
        mem_allowin_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wb_ClrStpJmp_in = 1'b1; exe_valid_in = 1'b0;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check32("flush_ready", 32'(md_ready_out), 32'h1);
        check32("flush_hi", md_hi_out, 32'h11);
        check32("flush_lo", md_lo_out, 32'h22);
        run_op(OP_MULT, 32'd3, 32'd4, 1'b1, st);
        check32("post_flush_stall", 32'(st), 32'd2);
        check32("post_flush_lo", md_lo_out, 32'd12);
        check32("post_flush_hi", md_hi_out, 32'd0);

        // DONE held three cycles without allowin.
        run_op(OP_MULT, 32'd5, 32'd6, 1'b0, st);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check32("hold_ready", 32'(md_ready_out), 32'h1);
            check32("hold_lo", md_lo_out, 32'd12);
        end
        @(posedge clk); #1;
        mem_allowin_in = 1'b1;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check32("hold_commit_lo", md_lo_out, 32'd30);
        check32("hold_commit_hi", md_hi_out, 32'd0);

        // mthi then an mfhi in the following cycle.
        @(posedge clk); #1;
        exe_valid_in = 1'b1; exe_md_op_in = OP_MTHI; exe_in1_in = 32'hABCD; mem_allowin_in = 1'b1;
        @(negedge clk);
        check32("mthi_ready", 32'(md_ready_out), 32'h1);
        @(posedge clk); #1;
        exe_md_op_in = '0; exe_md_read_in = 1'b1; exe_in1_in = '0;
        @(negedge clk);
        check32("mfhi_ready", 32'(md_ready_out), 32'h1);
        check32("mfhi_hi", md_hi_out, 32'hABCD);
        @(posedge clk); #1;
        idle();

        // Flush and DONE commit in the same cycle: no write.
        run_op(OP_MULT, 32'd7, 32'd7, 1'b0, st);
        @(posedge clk); #1;
        mem_allowin_in = 1'b1; wb_ClrStpJmp_in = 1'b1;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check32("flush_commit_lo", md_lo_out, 32'd30);
        check32("flush_commit_hi", md_hi_out, 32'hABCD);

        // Randomized traffic; the per-cycle compare process does the checking.
        @(posedge clk); #1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                exe_valid_in = 1'b0;
                exe_md_op_in = 6'(1 << $urandom_range(0, 5));
                mem_allowin_in = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            r = int'($urandom_range(0, 7));
            op = (r < 6) ? 6'(1 << r) : 6'b0;
            exe_valid_in = 1'b1; exe_md_op_in = op;
            exe_in0_in = rv(); exe_in1_in = rv();
            exe_exception_in = ($urandom_range(0, 15) == 0);
            exe_md_read_in = 1'($urandom_range(0, 1));
            leave = 1'b0;
            for (int c = 0; c < 200 && !leave; c++) begin
                mem_allowin_in = ($urandom_range(0, 3) != 0);
                wb_ClrStpJmp_in = ($urandom_range(0, 59) == 0);
                if (c > 0 && $urandom_range(0, 1) == 1) begin
                    exe_in0_in = rv(); exe_in1_in = rv();
                end
                @(negedge clk);
                leave = (md_ready_out && mem_allowin_in) || wb_ClrStpJmp_in;
                @(posedge clk); #1;
            end
            wb_ClrStpJmp_in = 1'b0;
            if (!leave) begin
                checks++; failures++;
                $display("FAIL rand_timeout: txn %0d never left EXE", n);
            end
        end
        idle();

        // Reset and DONE commit in the same cycle: reset wins.
        run_op(OP_MULTU, 32'd9, 32'd9, 1'b0, st);
        @(posedge clk); #1;
        mem_allowin_in = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        check32("rst_commit_hi", md_hi_out, 32'h0);
        check32("rst_commit_lo", md_lo_out, 32'h0);
        check32("rst_commit_ready", 32'(md_ready_out), 32'h1);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
